// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - round-robin shared memory port with in-order read response routing
module mem_port_arb #(
  parameter int NREQ   = 2,
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int OUTS   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [NREQ-1:0]        req_write,
  input  logic [NREQ*MEM_AW-1:0] req_addr,
  input  logic [NREQ*MEM_DW-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_vld,
  output logic [MEM_DW-1:0]      rsp_data,
  output logic                   mem_req,
  output logic                   mem_write,
  output logic [MEM_AW-1:0]      mem_addr,
  output logic [MEM_DW-1:0]      mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rdata_vld,
  input  logic [MEM_DW-1:0]      mem_rdata,
  output logic                   err_unexp,
  output logic                   busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW  = (OUTS > 1) ? $clog2(OUTS) : 1;
  localparam int CW  = PW + 1;

  // output stage
  logic              stg_full;
  logic              stg_write;
  logic [MEM_AW-1:0] stg_addr;
  logic [MEM_DW-1:0] stg_wdata;

  // arbitration
  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   elig;
  logic              gnt_any;
  logic [IDW-1:0]    gnt_id;
  int                idx;
  logic              sel_write;
  logic [MEM_AW-1:0] sel_addr;
  logic [MEM_DW-1:0] sel_wdata;

  // outstanding-read ID FIFO
  logic [IDW-1:0]    fifo_mem [OUTS];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [IDW-1:0]    head_id;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              err_q;

  logic              stg_free;
  logic              can_accept;
  logic              rd_room;

  // The stage can take a new entry when it is empty or handing its entry to memory now.
  // Read room is judged on the registered count only, so a same-cycle pop never helps.
  assign stg_free   = stg_full & mem_gnt;
  assign can_accept = ~stg_full | stg_free;
  assign rd_room    = (cnt < CW'(OUTS));
  assign fifo_empty = (cnt == '0);

  // Per-requester eligibility: writes only need stage space, reads also need FIFO room
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_vld[i] & can_accept & (req_write[i] | rd_room);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible requester wins
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_any && elig[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  // One-hot accept back to the winner only
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rdy[i] = gnt_any && (gnt_id == IDW'(i));
    end
  end

  assign sel_write = req_write[gnt_id];
  assign sel_addr  = req_addr[int'(gnt_id)*MEM_AW +: MEM_AW];
  assign sel_wdata = req_wdata[int'(gnt_id)*MEM_DW +: MEM_DW];

  assign push = gnt_any & ~sel_write;
  assign pop  = mem_rdata_vld & ~fifo_empty;

  // Output stage: load on grant, hold stable until memory grants, then empty
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_full  <= 1'b0;
      stg_write <= 1'b0;
      stg_addr  <= '0;
      stg_wdata <= '0;
    end else if (gnt_any) begin
      stg_full  <= 1'b1;
      stg_write <= sel_write;
      stg_addr  <= sel_addr;
      stg_wdata <= sel_wdata;
    end else if (stg_free) begin
      stg_full  <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner; it holds when nobody is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // ID FIFO storage: winner ID of every accepted read, in issue order
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= gnt_id;
    end
  end

  // ID FIFO pointers and occupancy; pointers wrap naturally since OUTS is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky flag for read data that nobody is waiting for
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (mem_rdata_vld && fifo_empty) begin
      err_q <= 1'b1;
    end
  end

  assign head_id = fifo_mem[rd_ptr];

  // Route returning read data to the requester at the FIFO head
  always_comb begin
    rsp_vld = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_vld[i] = pop && (head_id == IDW'(i));
    end
  end

  assign rsp_data  = mem_rdata;
  assign mem_req   = stg_full;
  assign mem_write = stg_write;
  assign mem_addr  = stg_addr;
  assign mem_wdata = stg_wdata;
  assign err_unexp = err_q;
  assign busy      = stg_full | ~fifo_empty;

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - scoreboard bench for mem_port_arb with a small memory model
module tb_mem_port_arb;

  localparam int NREQ = 2;
  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int OUTS = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_vld;
  logic [NREQ-1:0]      req_rdy;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_vld;
  logic [DW-1:0]        rsp_data;
  logic                 mem_req;
  logic                 mem_write;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_gnt;
  logic                 mem_rdata_vld;
  logic [DW-1:0]        mem_rdata;
  logic                 err_unexp;
  logic                 busy;

  mem_port_arb #(.NREQ(NREQ), .MEM_AW(AW), .MEM_DW(DW), .OUTS(OUTS)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata_vld(mem_rdata_vld), .mem_rdata(mem_rdata),
    .err_unexp(err_unexp), .busy(busy)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  typedef struct {
    logic [NREQ-1:0] vld;
    logic [DW-1:0]   data;
  } rsp_t;

  mem_t exp_mem [$];
  rsp_t exp_rsp [$];

  logic [AW-1:0] pend_addr [$];
  int            pend_due  [$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int auto_rsp = 1;
  int rel_req = 0, rel_done = 0;
  int spur_req = 0, spur_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] rdata_of(input logic [AW-1:0] a);
    if (a == 16'h0010) return 32'h0000_CAFE;
    return {16'hD00D, a};
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_vld[i]            = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs;
    req_vld   = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic push_mem(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_t e;
    e.wr = w; e.addr = a; e.wdata = d;
    exp_mem.push_back(e);
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] v, input logic [DW-1:0] d);
    rsp_t e;
    e.vld = v; e.data = d;
    exp_rsp.push_back(e);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((busy !== 1'b0 || pend_addr.size() != 0) && n < 60) begin
      next_cycle();
      n++;
    end
    chk("drain_in_time", 64'(n < 60), 64'(1));
  endtask

  // memory model: capture accepted reads away from the clock edge
  always @(negedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else if (mem_req && mem_gnt && !mem_write) begin
      pend_addr.push_back(mem_addr);
      pend_due.push_back(cyc + 2);
    end
  end

  // memory model: return read data in order, two cycles after acceptance or on release
  initial begin
    mem_rdata_vld = 1'b0;
    mem_rdata     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (pend_addr.size() != 0 &&
          ((auto_rsp != 0) ? (pend_due[0] <= cyc) : (rel_req != rel_done))) begin
        mem_rdata_vld = 1'b1;
        mem_rdata     = rdata_of(pend_addr.pop_front());
        void'(pend_due.pop_front());
        if (auto_rsp == 0) rel_done++;
      end else if (spur_req != spur_done) begin
        mem_rdata_vld = 1'b1;
        mem_rdata     = 32'h0BAD_0BAD;
        spur_done++;
      end else begin
        mem_rdata_vld = 1'b0;
        mem_rdata     = '0;
      end
    end
  end

  // scoreboard monitor: memory handshakes and read responses
  always @(negedge clk) begin
    mem_t em;
    rsp_t er;
    if (!rst && mem_req && mem_gnt) begin
      if (exp_mem.size() == 0) chk("mem_unexpected_txn", 64'(exp_mem.size()), 64'(1));
      else begin
        em = exp_mem.pop_front();
        chk("mem_write", 64'(mem_write), 64'(em.wr));
        chk("mem_addr", 64'(mem_addr), 64'(em.addr));
        if (em.wr) chk("mem_wdata", 64'(mem_wdata), 64'(em.wdata));
      end
    end
    if (rsp_vld != '0) begin
      if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(rsp_vld), 64'(0));
      else begin
        er = exp_rsp.pop_front();
        chk("rsp_vld", 64'(rsp_vld), 64'(er.vld));
        chk("rsp_data", 64'(rsp_data), 64'(er.data));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] a;
    rst = 1'b1;
    mem_gnt = 1'b0;
    clear_reqs();
    repeat (3) next_cycle();
    rst = 1'b0;
    mid();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_write", 64'(mem_write), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_err", 64'(err_unexp), 64'(0));

    // single read
    next_cycle();
    mem_gnt = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0010, '0);
    push_mem(1'b0, 16'h0010, '0);
    push_rsp(2'b01, 32'h0000_CAFE);
    mid(); chk("t1_rdy_c0", 64'(req_rdy), 64'(2'b01));
    next_cycle(); clear_reqs();
    mid(); chk("t1_mem_req_c1", 64'(mem_req), 64'(1));
    chk("t1_mem_addr_c1", 64'(mem_addr), 64'(16'h0010));
    next_cycle();
    mid(); chk("t1_mem_req_c2", 64'(mem_req), 64'(0));
    chk("t1_busy_c2", 64'(busy), 64'(1));
    next_cycle();
    mid(); chk("t1_rsp_c3", 64'(rsp_vld), 64'(2'b01));
    next_cycle();
    mid(); chk("t1_busy_c4", 64'(busy), 64'(0));

    // round-robin fairness with both requesters streaming reads
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      set_req(0, 1'b1, 1'b0, 16'h0100 + 16'(k), '0);
      set_req(1, 1'b1, 1'b0, 16'h0200 + 16'(k), '0);
      a = ((k % 2) != 0) ? 16'h0200 + 16'(k) : 16'h0100 + 16'(k);
      push_mem(1'b0, a, '0);
      push_rsp(((k % 2) != 0) ? 2'b10 : 2'b01, rdata_of(a));
      mid();
      chk("t2_rr_rdy", 64'(req_rdy), ((k % 2) != 0) ? 64'(2'b10) : 64'(2'b01));
    end
    next_cycle(); clear_reqs();
    drain();

    // backpressure with a staged write
    next_cycle();
    mem_gnt = 1'b0;
    set_req(0, 1'b1, 1'b1, 16'h0020, 32'h0000_1234);
    push_mem(1'b1, 16'h0020, 32'h0000_1234);
    mid(); chk("t3_rdy_c0", 64'(req_rdy), 64'(2'b01));
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      set_req(0, 1'b0, 1'b0, '0, '0);
      set_req(1, 1'b1, 1'b1, 16'h0030, 32'h0000_5678);
      mid();
      chk("t3_stall_rdy", 64'(req_rdy), 64'(0));
      chk("t3_stall_req", 64'(mem_req), 64'(1));
      chk("t3_stall_addr", 64'(mem_addr), 64'(16'h0020));
      chk("t3_stall_wdata", 64'(mem_wdata), 64'(32'h0000_1234));
    end
    next_cycle();
    mem_gnt = 1'b1;
    push_mem(1'b1, 16'h0030, 32'h0000_5678);
    mid(); chk("t3_rdy_on_gnt", 64'(req_rdy), 64'(2'b10));
    next_cycle(); clear_reqs();
    mid(); chk("t3_second_addr", 64'(mem_addr), 64'(16'h0030));
    drain();

    // outstanding limit, reads held by memory
    auto_rsp = 0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_req(0, 1'b1, 1'b0, 16'h0400 + 16'(k), '0);
      push_mem(1'b0, 16'h0400 + 16'(k), '0);
      push_rsp(2'b01, rdata_of(16'h0400 + 16'(k)));
      mid(); chk("t4_rd_accept", 64'(req_rdy), 64'(2'b01));
    end
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0404, '0);
    set_req(1, 1'b1, 1'b1, 16'h0500, 32'hAAAA_5555);
    push_mem(1'b1, 16'h0500, 32'hAAAA_5555);
    mid(); chk("t4_write_while_full", 64'(req_rdy), 64'(2'b10));
    chk("t4_busy", 64'(busy), 64'(1));
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0405, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    mid(); chk("t4_read_stalled", 64'(req_rdy), 64'(0));
    rel_req++;
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0406, '0);
    mid(); chk("t4_pop_no_relax", 64'(req_rdy), 64'(0));
    chk("t4_release_rsp", 64'(rsp_vld), 64'(2'b01));
    next_cycle();
    set_req(0, 1'b1, 1'b0, 16'h0407, '0);
    push_mem(1'b0, 16'h0407, '0);
    push_rsp(2'b01, rdata_of(16'h0407));
    mid(); chk("t4_released", 64'(req_rdy), 64'(2'b01));
    auto_rsp = 1;
    next_cycle(); clear_reqs();
    drain();

    // mixed traffic: req0 reads, req1 writes; pointer currently favours requester 1
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      set_req(0, 1'b1, 1'b0, 16'h0600 + 16'(k), '0);
      set_req(1, 1'b1, 1'b1, 16'h0700 + 16'(k), 32'h7000_0000 + 32'(k));
      if ((k % 2) == 0) begin
        push_mem(1'b1, 16'h0700 + 16'(k), 32'h7000_0000 + 32'(k));
      end else begin
        push_mem(1'b0, 16'h0600 + 16'(k), '0);
        push_rsp(2'b01, rdata_of(16'h0600 + 16'(k)));
      end
      mid();
      chk("t5_mixed_rdy", 64'(req_rdy), ((k % 2) == 0) ? 64'(2'b10) : 64'(2'b01));
    end
    next_cycle(); clear_reqs();
    drain();

    // unexpected read data
    mid(); chk("t6_err_before", 64'(err_unexp), 64'(0));
    spur_req++;
    next_cycle();
    mid(); chk("t6_spur_no_rsp", 64'(rsp_vld), 64'(0));
    next_cycle();
    mid(); chk("t6_err_set", 64'(err_unexp), 64'(1));
    repeat (3) next_cycle();
    mid(); chk("t6_err_sticky", 64'(err_unexp), 64'(1));

    // reset in the middle of traffic
    next_cycle();
    mem_gnt = 1'b0;
    set_req(0, 1'b1, 1'b0, 16'h0800, '0);
    set_req(1, 1'b1, 1'b0, 16'h0900, '0);
    mid(); chk("t6_pre_rst_rdy", 64'(req_rdy), 64'(2'b10));
    next_cycle(); rst = 1'b1;
    mid(); chk("t6_staged_before_rst", 64'(mem_req), 64'(1));
    next_cycle(); rst = 1'b0; clear_reqs();
    mid();
    chk("t6_post_mem_req", 64'(mem_req), 64'(0));
    chk("t6_post_mem_write", 64'(mem_write), 64'(0));
    chk("t6_post_mem_addr", 64'(mem_addr), 64'(0));
    chk("t6_post_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("t6_post_rsp_vld", 64'(rsp_vld), 64'(0));
    chk("t6_post_busy", 64'(busy), 64'(0));
    chk("t6_post_err", 64'(err_unexp), 64'(0));
    next_cycle();
    mem_gnt = 1'b1;
    set_req(0, 1'b1, 1'b0, 16'h0800, '0);
    set_req(1, 1'b1, 1'b0, 16'h0900, '0);
    push_mem(1'b0, 16'h0800, '0);
    push_rsp(2'b01, rdata_of(16'h0800));
    mid(); chk("t6_first_after_rst", 64'(req_rdy), 64'(2'b01));
    next_cycle(); clear_reqs();
    drain();
    mid(); chk("t6_err_clean", 64'(err_unexp), 64'(0));

    chk("exp_mem_empty", 64'(exp_mem.size()), 64'(0));
    chk("exp_rsp_empty", 64'(exp_rsp.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
